line_buf_multi: RTL

- Parametrised multi-line buffer for the 2-D window filters (median filter front end); successor to the single-line delay buffer.
- Stores NUM_LINES previous video lines in inferred simple-dual-port RAMs. Each accepted pixel produces a vertical column of NUM_LINES+1 vertically aligned taps: the current pixel plus the pixels from 1..NUM_LINES lines above it.
- Line width is set at run time, up to MAX_WIDTH. The block also reports start-of-frame, end-of-line and how many valid lines are filled, so downstream window logic can handle the top edge.

---
 rtl/line_buf_multi_if.sv | 39 +++
 rtl/line_buf_multi.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/line_buf_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_multi_if
//  Description : Pixel-in / tap-column-out stream bundle for line_buf_multi.
//                The master drives the pixel stream and line-width config;
//                the slave (the line buffer) returns the vertical tap column.
//  Revision    : 1.0  initial release
// ============================================================================
interface line_buf_multi_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LINES  = 2,
    parameter int MAX_WIDTH  = 1024
);
    localparam int ADDR_WIDTH  = $clog2(MAX_WIDTH);
    localparam int LINES_WIDTH = $clog2(NUM_LINES + 1);

    logic [ADDR_WIDTH:0]                  cfg_width;
    logic                                 in_valid;
    logic                                 in_sof;
    logic [DATA_WIDTH-1:0]                in_data;

    logic                                 out_valid;
    logic [(NUM_LINES+1)*DATA_WIDTH-1:0]  out_taps;
    logic                                 out_sof;
    logic                                 out_eol;
    logic [ADDR_WIDTH-1:0]                out_col;
    logic [LINES_WIDTH-1:0]               out_lines;

    modport master (
        output cfg_width, in_valid, in_sof, in_data,
        input  out_valid, out_taps, out_sof, out_eol, out_col, out_lines
    );

    modport slave (
        input  cfg_width, in_valid, in_sof, in_data,
        output out_valid, out_taps, out_sof, out_eol, out_col, out_lines
    );
endinterface
`default_nettype wire

// File: rtl/line_buf_multi.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_multi
//  Description : Multi-line video buffer. Keeps NUM_LINES previous lines in
//                cascaded simple-dual-port RAMs and emits, one cycle after
//                each accepted pixel, a column of NUM_LINES+1 vertically
//                aligned taps plus frame/line position markers.
//  Revision    : 1.0  initial release
// ============================================================================
module line_buf_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LINES  = 2,
    parameter int MAX_WIDTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(MAX_WIDTH)
) (
    input  wire             clk,
    input  wire             rst_n,
    line_buf_multi_if.slave bus
);

    localparam int                     c_lines_w   = $clog2(NUM_LINES + 1);
    localparam logic [ADDR_WIDTH:0]    c_max_width = (ADDR_WIDTH+1)'(MAX_WIDTH);
    localparam logic [ADDR_WIDTH:0]    c_min_width = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]    c_width_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0]  c_col_one   = ADDR_WIDTH'(1);
    localparam logic [c_lines_w-1:0]   c_num_lines = c_lines_w'(NUM_LINES);
    localparam logic [c_lines_w-1:0]   c_lines_one = c_lines_w'(1);

    // A width of at least 2 guarantees the read column and the pending write
    // column are never the same, so the RAMs need no bypass path.
    function automatic logic [ADDR_WIDTH:0] clamp_width(input logic [ADDR_WIDTH:0] w);
        if (w < c_min_width) begin
            return c_min_width;
        end else if (w > c_max_width) begin
            return c_max_width;
        end else begin
            return w;
        end
    endfunction

    // Stage-0 control state
    logic [ADDR_WIDTH:0]    r_width;
    logic [ADDR_WIDTH-1:0]  r_col;
    logic [c_lines_w-1:0]   r_line_cnt;

    // Stage-0 combinational decode
    logic [ADDR_WIDTH:0]    w_cfg_clamped;
    logic [ADDR_WIDTH:0]    w_width_eff;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic                   w_last;

    // Stage-1 registers (output side and pending write)
    logic                   r_out_valid;
    logic                   r_out_sof;
    logic                   r_out_eol;
    logic [ADDR_WIDTH-1:0]  r_out_col;
    logic [c_lines_w-1:0]   r_out_lines;
    logic [DATA_WIDTH-1:0]  r_data_d;

    // RAM read data (index k = line k+1 above) and cascade write data
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0] w_wr_data;

    // A start-of-frame pixel uses the freshly loaded width and column 0.
    always_comb begin
        w_cfg_clamped = clamp_width(bus.cfg_width);
        w_width_eff   = bus.in_sof ? w_cfg_clamped : r_width;
        w_rd_addr     = bus.in_sof ? '0 : r_col;
        w_last        = ({1'b0, w_rd_addr} == (w_width_eff - c_width_one));
    end

    // Column counter, line fill counter and active width
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_width    <= w_cfg_clamped;
            r_col      <= '0;
            r_line_cnt <= '0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) begin
                r_width <= w_cfg_clamped;
            end
            r_col <= w_last ? '0 : (w_rd_addr + c_col_one);
            if (bus.in_sof) begin
                r_line_cnt <= '0;
            end else if (w_last && (r_line_cnt != c_num_lines)) begin
                r_line_cnt <= r_line_cnt + c_lines_one;
            end
        end
    end

    // Output stage: markers pulse only with out_valid, data fields hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_col   <= '0;
            r_out_lines <= '0;
            r_data_d    <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            r_out_sof   <= bus.in_valid & bus.in_sof;
            r_out_eol   <= bus.in_valid & w_last;
            if (bus.in_valid) begin
                r_out_col   <= w_rd_addr;
                r_out_lines <= bus.in_sof ? '0 : r_line_cnt;
                r_data_d    <= bus.in_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [DATA_WIDTH-1:0] r_mem [MAX_WIDTH];
        logic [DATA_WIDTH-1:0] r_rd_q;

        // Line k receives the pixel that just left line k-1 (cascade shift)
        if (k == 0) begin : g_head
            assign w_wr_data[k] = r_data_d;
        end else begin : g_cascade
            assign w_wr_data[k] = w_rd_data[k-1];
        end

        assign w_rd_data[k] = r_rd_q;

        // Write port: commit the column read one cycle earlier
        always_ff @(posedge clk) begin
            if (r_out_valid) begin
                r_mem[r_out_col] <= w_wr_data[k];
            end
        end

        // Registered read port, one-cycle latency
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rd_q <= '0;
            end else if (bus.in_valid) begin
                r_rd_q <= r_mem[w_rd_addr];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eol   = r_out_eol;
    assign bus.out_col   = r_out_col;
    assign bus.out_lines = r_out_lines;
    assign bus.out_taps  = {w_rd_data, r_data_d};

endmodule
`default_nettype wire
